axis_ctrlsrc_cal_ctrl: RTL

- Sequencing controller for the control-source select datapath (offset removal, linear/log path mux).
- Runs auto-zero calibration: settle, average 2^K raw input samples, then drive the datapath's signal_offset input with the negated mean.
- Sequences linear/log path changes (selection_ln) behind a hold window so the downstream feedback loop never integrates a switching transient.
- Sits beside the select block, and is driven by the PS configuration registers.

---
 rtl/axis_ctrlsrc_cal_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axis_ctrlsrc_cal_ctrl.sv
// axis_ctrlsrc_cal_ctrl: auto-zero calibration of the control-source offset and
// hold-window sequencing of linear/log path changes for the select block.
// Optional macro CAL_ROUND_EN: the calibrated mean is rounded to nearest
// instead of truncated toward -inf. Timing is identical either way.
module axis_ctrlsrc_cal_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ACC_EXTRA      = 16,
  parameter int HOLD_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  a_clk,
  input  logic                  a_resetn,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                  S_AXIS_tvalid,
  input  logic                  cal_start,
  input  logic                  cal_abort,
  input  logic [4:0]            avg_log2,
  input  logic [15:0]           settle_cycles,
  input  logic [DATA_WIDTH-1:0] manual_offset,
  input  logic                  use_manual,
  input  logic [1:0]            selection_ln_req,
  output logic [DATA_WIDTH-1:0] signal_offset,
  output logic [1:0]            selection_ln,
  output logic                  ctrl_hold,
  output logic                  cal_busy,
  output logic                  cal_done,
  output logic                  cal_error
);
  localparam int AW = DATA_WIDTH + ACC_EXTRA;
  localparam int KW = $clog2(ACC_EXTRA + 1);
  localparam int CW = (ACC_EXTRA + 1 > 17) ? ACC_EXTRA + 1 : 17;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic signed [AW+1:0] SMAX = {{(AW+3-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW+1:0] SMIN = {{(AW+3-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, COMPUTE, APPLY} cal_st_t;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST} seq_st_t;

  cal_st_t               r_cal_st, w_cal_nxt;
  seq_st_t               r_seq_st, w_seq_nxt;
  logic                  r_start_d, r_done, r_err, r_apply_d;
  logic [KW-1:0]         r_k;
  logic [15:0]           r_settle;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_to;
  logic signed [AW-1:0]  r_acc;
  logic [DATA_WIDTH-1:0] r_neg, r_cal_off, r_sig_off;
  logic [HW-1:0]         r_hcnt;
  logic [1:0]            r_sel, r_sel_lat;

  logic                  w_start_rise, w_busy, w_to_hit, w_acc_last, w_run;
  logic [KW-1:0]         w_k_clamp;
  logic [CW-1:0]         w_cnt_last;
  logic signed [AW:0]    w_acc_rnd, w_mean;
  logic signed [AW+1:0]  w_neg;
  logic [DATA_WIDTH-1:0] w_neg_sat;

  assign w_start_rise = cal_start & ~r_start_d;
  assign w_busy       = (r_cal_st != IDLE);
  assign w_run        = (r_cal_st == SETTLE) || (r_cal_st == ACCUM);
  assign w_to_hit     = w_run && !S_AXIS_tvalid && (r_to == TW'(TIMEOUT_CYCLES - 1));
  assign w_k_clamp    = (int'(avg_log2) > ACC_EXTRA) ? KW'(ACC_EXTRA) : KW'(avg_log2);
  assign w_cnt_last   = (CW'(1) << r_k) - CW'(1);
  assign w_acc_last   = S_AXIS_tvalid && (r_cnt == w_cnt_last);

  // Mean of the accumulated samples, negated and clamped to the output range
  always_comb begin
    w_acc_rnd = {r_acc[AW-1], r_acc};
`ifdef CAL_ROUND_EN
    if (r_k != '0)
      w_acc_rnd = {r_acc[AW-1], r_acc} + ((AW+1)'(1) << (r_k - KW'(1)));
`endif
    w_mean = w_acc_rnd >>> r_k;
    w_neg  = -{w_mean[AW], w_mean};
    if (w_neg > SMAX)      w_neg_sat = SMAX[DATA_WIDTH-1:0];
    else if (w_neg < SMIN) w_neg_sat = SMIN[DATA_WIDTH-1:0];
    else                   w_neg_sat = w_neg[DATA_WIDTH-1:0];
  end

  // Calibration next-state; abort beats timeout beats normal progress
  always_comb begin
    w_cal_nxt = r_cal_st;
    case (r_cal_st)
      IDLE:    if (w_start_rise) w_cal_nxt = SETTLE;
      SETTLE:  if (cal_abort || w_to_hit) w_cal_nxt = IDLE;
               else if (r_cnt == CW'(r_settle)) w_cal_nxt = ACCUM;
      ACCUM:   if (cal_abort || w_to_hit) w_cal_nxt = IDLE;
               else if (w_acc_last) w_cal_nxt = COMPUTE;
      COMPUTE: w_cal_nxt = cal_abort ? IDLE : APPLY;
      APPLY:   w_cal_nxt = IDLE;
      default: w_cal_nxt = IDLE;
    endcase
  end

  // Calibration state register and datapath
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      r_cal_st  <= IDLE;
      r_start_d <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_apply_d <= 1'b0;
      r_k       <= '0;
      r_settle  <= '0;
      r_cnt     <= '0;
      r_to      <= '0;
      r_acc     <= '0;
      r_neg     <= '0;
      r_cal_off <= '0;
      r_sig_off <= '0;
    end else begin
      r_cal_st  <= w_cal_nxt;
      r_start_d <= cal_start;
      r_done    <= 1'b0;
      r_apply_d <= (r_cal_st == APPLY);
      r_sig_off <= use_manual ? manual_offset : r_cal_off;
      r_to      <= (w_run && !S_AXIS_tvalid) ? r_to + 1'b1 : '0;
      if (w_to_hit && !cal_abort) r_err <= 1'b1;
      case (r_cal_st)
        IDLE: if (w_start_rise) begin
          r_acc    <= '0;
          r_cnt    <= '0;
          r_to     <= '0;
          r_err    <= 1'b0;
          r_k      <= w_k_clamp;
          r_settle <= settle_cycles;
        end
        SETTLE: begin
          if (r_cnt == CW'(r_settle)) r_cnt <= '0;
          else if (S_AXIS_tvalid)     r_cnt <= r_cnt + 1'b1;
        end
        ACCUM: if (S_AXIS_tvalid) begin
          r_acc <= r_acc + {{ACC_EXTRA{S_AXIS_tdata[DATA_WIDTH-1]}}, S_AXIS_tdata};
          r_cnt <= r_cnt + 1'b1;
        end
        COMPUTE: r_neg <= w_neg_sat;
        APPLY: if (!cal_abort) begin
          r_cal_off <= r_neg;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Selection sequencer next-state; new requests wait for idle and no calibration
  always_comb begin
    w_seq_nxt = r_seq_st;
    case (r_seq_st)
      S_IDLE:  if ((selection_ln_req != r_sel) && !w_busy) w_seq_nxt = S_PRE;
      S_PRE:   if (r_hcnt == HW'(HOLD_CYCLES - 1)) w_seq_nxt = S_POST;
      S_POST:  if (r_hcnt == HW'(HOLD_CYCLES - 1)) w_seq_nxt = S_IDLE;
      default: w_seq_nxt = S_IDLE;
    endcase
  end

  // Selection sequencer state, hold counter and path select register
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      r_seq_st  <= S_IDLE;
      r_hcnt    <= '0;
      r_sel     <= '0;
      r_sel_lat <= '0;
    end else begin
      r_seq_st <= w_seq_nxt;
      r_hcnt   <= (r_seq_st == w_seq_nxt) ? r_hcnt + 1'b1 : '0;
      if (r_seq_st == S_IDLE) r_hcnt <= '0;
      if (r_seq_st == S_IDLE && w_seq_nxt == S_PRE) r_sel_lat <= selection_ln_req;
      if (r_seq_st == S_PRE && w_seq_nxt == S_POST) r_sel <= r_sel_lat;
    end
  end

  assign signal_offset = r_sig_off;
  assign selection_ln  = r_sel;
  assign ctrl_hold     = (r_seq_st != S_IDLE) || (r_cal_st == APPLY) || r_apply_d;
  assign cal_busy      = w_busy;
  assign cal_done      = r_done;
  assign cal_error     = r_err;
endmodule
